// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the sequential signed divider
//
// Purpose: FSM state and rounding-mode enums, plus a conditional
//          two's-complement negate used both to take operand magnitudes
//          and to re-apply result signs.
// Ports:   none (package).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef enum logic {
    DIV_TRUNC = 1'b0,
    DIV_FLOOR = 1'b1
  } div_mode_e;

  // Working width for the helper; callers extend into it and cast the
  // result back down, so one function serves every operand width.
  localparam int MAG_W = 64;

  // Returns -v when neg is set, else v. With neg = sign bit of a
  // sign-extended value this yields the magnitude.
  function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v,
                                                input logic             neg);
    return neg ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring subtract/select stage of the divider
//
// Purpose: subtracts the divisor magnitude from the shifted partial
//          remainder with a full-adder ripple chain (inverted divisor,
//          carry-in 1). Carry-out 1 means no borrow: qbit=1 and the
//          difference is kept; otherwise the input is restored.
// Ports:
//   rem_i   in  W  shifted partial remainder
//   div_i   in  W  divisor magnitude
//   rem_o   out W  next partial remainder
//   qbit_o  out 1  quotient bit for this step
module div_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W:0]   carry;
  logic [W-1:0] diff;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic b_n;
    assign b_n        = ~div_i[i];
    assign diff[i]    = rem_i[i] ^ b_n ^ carry[i];
    assign carry[i+1] = (rem_i[i] & b_n) | (carry[i] & (rem_i[i] ^ b_n));
  end

  assign qbit_o = carry[W];
  assign rem_o  = qbit_o ? diff : rem_i;

endmodule

// File: rtl/div_seq_sgn.sv
// rtl/div_seq_sgn.sv - iterative radix-2 signed restoring divider
//
// Purpose: one quotient bit per clock, truncate or floor rounding chosen
//          per operation, valid/ready handshakes on input and output.
//          Optional divide-by-zero fast path: define DIV_SEQ_SGN_DIVZERO_EN.
// Ports:
//   clk_i    in   1       clock, rising edge
//   rst_i    in   1       synchronous reset, active-high
//   valid_i  in   1       operand valid
//   ready_o  out  1       divider idle, can accept operands
//   X        in   widthX  dividend (signed)
//   Y        in   widthY  divisor (signed)
//   mode_i   in   1       0 = truncate, 1 = floor; sampled at accept
//   valid_o  out  1       result valid
//   ready_i  in   1       consumer accepts result
//   Q        out  widthX  quotient (signed)
//   R        out  widthY  remainder (signed)
//   ovf_o    out  1       quotient overflow (most negative X / -1)
//   dz_o     out  1       divide by zero (0 unless DIV_SEQ_SGN_DIVZERO_EN)
module div_seq_sgn
  import div_pkg::*;
#(
  parameter int widthX = 16,
  parameter int widthY = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [widthX-1:0] X,
  input  logic [widthY-1:0] Y,
  input  logic              mode_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [widthX-1:0] Q,
  output logic [widthY-1:0] R,
  output logic              ovf_o,
  output logic              dz_o
);

  // One extra bit so |Y| of the most negative divisor fits.
  localparam int RW = widthY + 1;
  localparam int CW = (widthX > 1) ? $clog2(widthX) : 1;

  div_state_e        state_q, state_d;
  logic [widthX-1:0] absx_q, absx_d;   // |X| shifts out the top, |Q| shifts in the bottom
  logic [RW-1:0]     absy_q, absy_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic              sgnx_q, sgnx_d;
  logic              sgny_q, sgny_d;
  div_mode_e         mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [widthX-1:0] q_q, q_d;
  logic [widthY-1:0] r_q, r_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
`ifdef DIV_SEQ_SGN_DIVZERO_EN
  logic              dz_q, dz_d;
`endif

  logic              accept;
  logic [RW-1:0]     step_in;
  logic [RW-1:0]     step_rem;
  logic              step_qbit;
  logic              neg_q;
  logic [widthX-1:0] q_trunc;
  logic [widthY-1:0] r_trunc;
  logic [widthY-1:0] y_signed;

  assign accept = valid_i & ready_q;

  // The remainder stays below |Y|, so its top bit is always clear and
  // dropping it on the shift loses nothing.
  assign step_in = RW'({rem_q, absx_q[widthX-1]});

  div_step #(.W(RW)) u_step (
    .rem_i  (step_in),
    .div_i  (absy_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  assign neg_q    = sgnx_q ^ sgny_q;
  assign q_trunc  = widthX'(twos_mag(MAG_W'(absx_q), neg_q));
  assign r_trunc  = widthY'(twos_mag(MAG_W'(rem_q), sgnx_q));
  assign y_signed = widthY'(twos_mag(MAG_W'(absy_q), sgny_q));

  always_comb begin
    state_d = state_q;
    absx_d  = absx_q;
    absy_d  = absy_q;
    rem_d   = rem_q;
    sgnx_d  = sgnx_q;
    sgny_d  = sgny_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
`ifdef DIV_SEQ_SGN_DIVZERO_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          absx_d  = widthX'(twos_mag(MAG_W'($signed(X)), X[widthX-1]));
          absy_d  = RW'(twos_mag(MAG_W'($signed(Y)), Y[widthY-1]));
          sgnx_d  = X[widthX-1];
          sgny_d  = Y[widthY-1];
          mode_d  = div_mode_e'(mode_i);
          rem_d   = '0;
          cnt_d   = CW'(widthX - 1);
          state_d = ITER;
`ifdef DIV_SEQ_SGN_DIVZERO_EN
          if (Y == '0) begin
            q_d     = '1;
            r_d     = X[widthY-1:0];
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ITER: begin
        rem_d  = step_rem;
        absx_d = {absx_q[widthX-2:0], step_qbit};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        q_d   = q_trunc;
        r_d   = r_trunc;
        // Same signs with |Q| reaching 2^(widthX-1) only happens for
        // min / -1; a zero divisor is excluded so it never flags.
        ovf_d = ~neg_q & absx_q[widthX-1] & (absy_q != '0);
`ifdef DIV_SEQ_SGN_DIVZERO_EN
        dz_d  = 1'b0;
`endif
        if (mode_q == DIV_FLOOR && neg_q && r_trunc != '0) begin
          q_d = q_trunc - widthX'(1);
          r_d = r_trunc + y_signed;
        end
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      absx_q  <= '0;
      absy_q  <= '0;
      rem_q   <= '0;
      sgnx_q  <= 1'b0;
      sgny_q  <= 1'b0;
      mode_q  <= DIV_TRUNC;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef DIV_SEQ_SGN_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      absx_q  <= absx_d;
      absy_q  <= absy_d;
      rem_q   <= rem_d;
      sgnx_q  <= sgnx_d;
      sgny_q  <= sgny_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
`ifdef DIV_SEQ_SGN_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign Q       = q_q;
  assign R       = r_q;
  assign ovf_o   = ovf_q;
`ifdef DIV_SEQ_SGN_DIVZERO_EN
  assign dz_o    = dz_q;
`else
  assign dz_o    = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_sgn.sv
// tb/tb_div_seq_sgn.sv - self-checking bench for div_seq_sgn
module tb_div_seq_sgn;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, mode_i, valid_o, ready_i, ovf_o, dz_o;
  logic [15:0] X, Q;
  logic [7:0]  Y, R;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  div_seq_sgn #(.widthX(16), .widthY(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .X       (X),
    .Y       (Y),
    .mode_i  (mode_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .Q       (Q),
    .R       (R),
    .ovf_o   (ovf_o),
    .dz_o    (dz_o)
  );

  // Runs one division. lat counts the accepting edge as 1 and stops at
  // the first sample with valid_o high (bounded at 100).
  task automatic do_div(input logic signed [15:0] x, input logic signed [7:0] y,
                        input logic m, output logic signed [15:0] q,
                        output logic signed [7:0] r, output logic ov,
                        output logic dz, output int lat);
    X = x; Y = y; mode_i = m; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; X = '0; Y = '0; mode_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    q = Q; r = R; ov = ovf_o; dz = dz_o;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; X = '0; Y = '0; mode_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tests_run++; if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    tests_run++; if (Q !== 16'h0) begin tests_failed++; $display("FAIL reset_q: got %h expected 0000", Q); end
    tests_run++; if (R !== 8'h0) begin tests_failed++; $display("FAIL reset_r: got %h expected 00", R); end
    tests_run++; if (ovf_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
    tests_run++; if (dz_o !== 1'b0) begin tests_failed++; $display("FAIL reset_dz: got %b expected 0", dz_o); end
  endtask

  task automatic test_trunc_basic;
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    do_div(16'sd100, 8'sd7, 1'b0, q, r, ov, dz, lat);
    tests_run++; if (q !== 16'sd14) begin tests_failed++; $display("FAIL basic_q: got %0d expected 14", q); end
    tests_run++; if (r !== 8'sd2) begin tests_failed++; $display("FAIL basic_r: got %0d expected 2", r); end
    tests_run++; if (lat != 18) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 18", lat); end
    tests_run++; if (ov !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf: got %b expected 0", ov); end
  endtask

  task automatic test_signs;
    int xs[4] = '{-100, -100, 100, -100};
    int ys[4] = '{7, 7, -7, -7};
    int ms[4] = '{0, 1, 1, 1};
    int eq[4] = '{-14, -15, -15, 14};
    int er[4] = '{-2, 5, -5, -2};
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    for (int i = 0; i < 4; i++) begin
      do_div(16'(xs[i]), 8'(ys[i]), ms[i][0], q, r, ov, dz, lat);
      tests_run++; if (q !== 16'(eq[i])) begin tests_failed++; $display("FAIL signs_q[%0d]: got %0d expected %0d", i, q, eq[i]); end
      tests_run++; if (r !== 8'(er[i])) begin tests_failed++; $display("FAIL signs_r[%0d]: got %0d expected %0d", i, r, er[i]); end
      tests_run++; if (lat != 18) begin tests_failed++; $display("FAIL signs_latency[%0d]: got %0d expected 18", i, lat); end
    end
  endtask

  task automatic test_boundary;
    int xs[6] = '{-32768, 5, -128, 32767, 32767, -32768};
    int ys[6] = '{-1, -128, -128, -128, -128, -128};
    int ms[6] = '{0, 0, 1, 0, 1, 0};
    int eq[6] = '{-32768, 0, 1, -255, -256, 256};
    int er[6] = '{0, 5, 0, 127, -1, 0};
    int eo[6] = '{1, 0, 0, 0, 0, 0};
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    for (int i = 0; i < 6; i++) begin
      do_div(16'(xs[i]), 8'(ys[i]), ms[i][0], q, r, ov, dz, lat);
      tests_run++; if (q !== 16'(eq[i])) begin tests_failed++; $display("FAIL bound_q[%0d]: got %0d expected %0d", i, q, eq[i]); end
      tests_run++; if (r !== 8'(er[i])) begin tests_failed++; $display("FAIL bound_r[%0d]: got %0d expected %0d", i, r, er[i]); end
      tests_run++; if (ov !== eo[i][0]) begin tests_failed++; $display("FAIL bound_ovf[%0d]: got %b expected %0d", i, ov, eo[i]); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    X = 16'sd100; Y = 8'sd7; mode_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    tests_run++; if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_timeout: got %b expected 1", valid_o); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      tests_run++; if (Q !== 16'd14 || R !== 8'd2) begin tests_failed++; $display("FAIL bp_hold[%0d]: got Q=%0d R=%0d expected Q=14 R=2", c, Q, R); end
      tests_run++; if (valid_o !== 1'b1 || ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_flags[%0d]: got valid=%b ready=%b expected valid=1 ready=0", c, valid_o, ready_o); end
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    tests_run++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", valid_o, ready_o); end
  endtask

  task automatic test_reset_mid;
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    logic saw_valid;
    X = 16'sd1000; Y = 8'sd3; mode_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    tests_run++; if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL mid_busy_ready: got %b expected 0", ready_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    tests_run++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_state: got valid=%b ready=%b expected valid=0 ready=1", valid_o, ready_o); end
    rst_i = 1'b0;
    ready_i = 1'b1;
    saw_valid = 1'b0;
    repeat (25) begin
      @(posedge clk_i); #1;
      if (valid_o) saw_valid = 1'b1;
    end
    ready_i = 1'b0;
    tests_run++; if (saw_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_result: got valid seen=%b expected 0", saw_valid); end
    do_div(-16'sd100, 8'sd7, 1'b0, q, r, ov, dz, lat);
    tests_run++; if (q !== -16'sd14 || r !== -8'sd2) begin tests_failed++; $display("FAIL mid_after_q_r: got Q=%0d R=%0d expected Q=-14 R=-2", q, r); end
  endtask

  task automatic test_model_sweep;
    int xs[10] = '{12345, -12345, 32767, -32767, -1, 7, -32768, 1000, 0, 255};
    int ys[10] = '{37, 37, 127, -128, 3, -3, 3, -1, -5, 16};
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    int eq, er, qi, ri;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 10; i++) begin
        eq = xs[i] / ys[i];
        er = xs[i] % ys[i];
        if (m == 1 && er != 0 && ((er < 0) != (ys[i] < 0))) begin
          eq = eq - 1;
          er = er + ys[i];
        end
        do_div(16'(xs[i]), 8'(ys[i]), m[0], q, r, ov, dz, lat);
        qi = int'(q);
        ri = int'(r);
        tests_run++; if (qi != eq || ri != er) begin tests_failed++; $display("FAIL sweep[m%0d,%0d]: got Q=%0d R=%0d expected Q=%0d R=%0d", m, i, qi, ri, eq, er); end
        tests_run++; if (qi * ys[i] + ri != xs[i]) begin tests_failed++; $display("FAIL sweep_inv[m%0d,%0d]: got %0d expected %0d", m, i, qi * ys[i] + ri, xs[i]); end
      end
    end
  endtask

`ifdef DIV_SEQ_SGN_DIVZERO_EN
  task automatic test_divzero;
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    do_div(16'h1234, 8'sd0, 1'b0, q, r, ov, dz, lat);
    tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    tests_run++; if (dz !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b expected 1", dz); end
    tests_run++; if (q !== 16'hFFFF || r !== 8'h34) begin tests_failed++; $display("FAIL dz_q_r: got Q=%h R=%h expected Q=ffff R=34", q, r); end
    tests_run++; if (ov !== 1'b0) begin tests_failed++; $display("FAIL dz_ovf: got %b expected 0", ov); end
  endtask
`else
  task automatic test_divzero;
    logic signed [15:0] q; logic signed [7:0] r; logic ov, dz; int lat;
    do_div(16'h1234, 8'sd0, 1'b0, q, r, ov, dz, lat);
    tests_run++; if (lat != 18) begin tests_failed++; $display("FAIL y0_latency: got %0d expected 18", lat); end
    tests_run++; if (dz !== 1'b0 || ov !== 1'b0) begin tests_failed++; $display("FAIL y0_flags: got dz=%b ovf=%b expected 0 0", dz, ov); end
    tests_run++; if ($isunknown({q, r})) begin tests_failed++; $display("FAIL y0_known: got Q=%h R=%h expected no X/Z", q, r); end
  endtask
`endif

  initial begin
    test_reset;
    test_trunc_basic;
    test_signs;
    test_boundary;
    test_backpressure;
    test_reset_mid;
    test_model_sweep;
    test_divzero;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
